ld_wb_sink: RTL and testbench
=============================

Name: ld_wb_sink

Overview:
- Consumer end of the load-result writeback interface driven by the load/store unit (vld_ld, indx_ld, phy_addr_ld, data_ld, reg_wrt_ld).
- Buffers load results in a small FIFO and arbitrates for the shared register-file write port against the ALU writeback path.
- Drives the physical register file write and the ROB completion strobe.
- Raises back-pressure (wb_full) toward the LSU stall logic.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- IDX_W, 6, ROB/LSQ index width.
- PREG_W, 6, physical register address width.
- DATA_W, 16, load data width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flsh  in  1  pipeline flush; discards all buffered and in-flight results.
- vld_ld  in  1  load result valid from LSU.
- indx_ld  in  IDX_W  ROB index of completing load.
- phy_addr_ld  in  PREG_W  destination physical register.
- data_ld  in  DATA_W  load data.
- reg_wrt_ld  in  1  1 = result writes RF; 0 = completion only.
- alu_wb_vld  in  1  ALU owns the RF write port this cycle (higher priority).
- rf_we  out  1  register file write enable.
- rf_waddr  out  PREG_W  register file write address.
- rf_wdata  out  DATA_W  register file write data.
- rob_cmpl_vld  out  1  ROB completion strobe.
- rob_cmpl_indx  out  IDX_W  ROB index completed.
- wb_full  out  1  back-pressure to LSU.
- ovf_err  out  1  sticky overflow error.

Behaviour:
- Reset (async, rst=1): head=tail=count=0. rf_we=0, rf_waddr=0, rf_wdata=0, rob_cmpl_vld=0, rob_cmpl_indx=0, wb_full=0, ovf_err=0.
- Push: on a rising edge with vld_ld=1 and flsh=0, write {indx_ld, phy_addr_ld, data_ld, reg_wrt_ld} at tail; tail increments mod DEPTH.
- Pop eligibility: count>0 and flsh=0, and either head.reg_wrt=0 or alu_wb_vld=0. Completion-only entries never need the RF port.
- Pop: head increments mod DEPTH. The output registers load on the same edge, so results appear the cycle after the pop decision:
  - rob_cmpl_vld=1, rob_cmpl_indx=head.indx.
  - rf_we=head.reg_wrt, rf_waddr=head.preg, rf_wdata=head.data.
- No pop: rf_we=0 and rob_cmpl_vld=0 next cycle. rf_waddr and rf_wdata hold their values.
- Latency: a result pushed into an empty FIFO at edge N is eligible in cycle N→N+1 and appears on the outputs after edge N+1. Minimum latency is 2 edges from vld_ld sampling.
- No bypass path.
- count update: +1 on push only, −1 on pop only, unchanged on simultaneous push and pop. Push and pop are allowed together at count=0 (the pop uses the old head only if count>0, so at count=0 only the push occurs) and at count=DEPTH.
- wb_full: combinational, 1 when count ≥ DEPTH−1. This gives a one-slot skid for the LSU's registered stall.
- Overflow: vld_ld=1 with count=DEPTH and no pop that cycle:
  - The entry is dropped.
  - ovf_err is set and stays set until rst.
  - count, head and tail are unchanged.
- Flush: flsh=1 at an edge clears head, tail and count, and forces rf_we=0 and rob_cmpl_vld=0 next cycle. A vld_ld in the same cycle is discarded. ovf_err is unaffected.
- Pointer wrap: head and tail are log2(DEPTH) bits and wrap naturally. count is log2(DEPTH)+1 bits.
- Ordering: strict FIFO. A completion-only entry behind a blocked RF-writing head waits; no reordering.
- Reset mid-operation: all state clears immediately (asynchronous). The first push may occur on the first edge after rst deasserts.

Decomposition:
- Shared package:
  - wb_entry_t struct {indx, preg, data, reg_wrt}.
  - IDX_W, PREG_W and DATA_W defaults.
  - The function clog2 for pointer widths.
- One natural sub-module: wb_fifo (storage, head/tail/count, full/empty, overflow detection).
- Top level holds the pop-eligibility arbitration and the output registers.

Test Plan:
- Single load: vld_ld=1, indx=1, preg=37, data=16'hFFFF, reg_wrt=1, alu_wb_vld=0 → two edges later rf_we=1, rf_waddr=37, rf_wdata=FFFF, rob_cmpl_vld=1, rob_cmpl_indx=1 for one cycle.
- Port conflict: push preg=28, data=16'h0101; hold alu_wb_vld=1 for 3 cycles → no rf_we during the hold. The write appears exactly one cycle after alu_wb_vld drops.
- Completion-only bypasses conflict: push reg_wrt=0, indx=5 while alu_wb_vld=1 → rob_cmpl_vld=1 with indx 5 and rf_we=0, despite the ALU holding the port.
- Fill and back-pressure: with alu_wb_vld=1, push 3 RF-writing loads → wb_full=1 after the 3rd. Push a 4th → count=4 and ovf_err stays 0. Push a 5th → ovf_err=1 and the entry is dropped. Release the port → indices drain in order 1, 2, 3, 4.
- Flush: push 2 entries, assert flsh together with a new vld_ld → next cycle count=0, wb_full=0, no rf_we or rob_cmpl_vld ever emitted for any of the three.
- Wrap and async reset: stream 10 back-to-back loads with the port free → all 10 complete in order, one per cycle. Pulse rst between clock edges mid-stream → all outputs go to 0 immediately.

Source files
------------

// File: rtl/ld_wb_sink_pkg.sv
// Shared definitions for the load-result writeback sink.
// Contents:
//   - default widths for the ROB index, physical register and load data
//   - wb_entry_t: one buffered load result at the default widths
//   - clog2: ceiling log2, used to size FIFO pointers and the occupancy count
package ld_wb_sink_pkg;

    localparam int IDX_W_DEF  = 6;
    localparam int PREG_W_DEF = 6;
    localparam int DATA_W_DEF = 16;

    typedef struct packed {
        logic [IDX_W_DEF-1:0]  indx;
        logic [PREG_W_DEF-1:0] preg;
        logic [DATA_W_DEF-1:0] data;
        logic                  reg_wrt;
    } wb_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/ld_wb_sink_wb_fifo.sv
// Circular buffer for load results awaiting writeback.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_flsh        discard every buffered entry; a same-cycle push is dropped
//   i_push_req    request to store i_wdata at the tail
//   i_wdata       entry to store
//   i_pop         consume the head entry (ignored when empty or flushing)
//   o_head        entry currently at the head
//   o_count       occupancy, 0..DEPTH
//   o_empty       occupancy is zero
//   o_ovf_err     sticky: a push arrived while full with no pop to make room
module ld_wb_sink_wb_fifo
    import ld_wb_sink_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 29
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_flsh,
    input  logic                  i_push_req,
    input  logic [W-1:0]          i_wdata,
    input  logic                  i_pop,
    output logic [W-1:0]          o_head,
    output logic [clog2(DEPTH):0] o_count,
    output logic                  o_empty,
    output logic                  o_ovf_err
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_ovf_err;

    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_ovf;

    assign w_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);

    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign w_pop  = i_pop && !o_empty && !i_flsh;
    assign w_push = i_push_req && !i_flsh && (!w_full || w_pop);
    assign w_ovf  = i_push_req && !i_flsh && w_full && !w_pop;

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: non-blocking assignments throughout sequential logic so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_ovf_err <= 1'b0;
        end else if (i_flsh) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_tail <= r_tail + 1'b1;
            if (w_pop)  r_head <= r_head + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (w_ovf) r_ovf_err <= 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the count gates every read, so
    // stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_tail] <= i_wdata;
    end

    assign o_head    = r_mem[r_head];
    assign o_count   = r_count;
    assign o_ovf_err = r_ovf_err;

endmodule

// File: rtl/ld_wb_sink.sv
// Load-result writeback sink: buffers LSU load results, arbitrates for the
// shared register-file write port (ALU has priority), and drives the RF write
// and ROB completion strobes from registers.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   flsh                           discard buffered and in-flight results
//   vld_ld, indx_ld, phy_addr_ld,
//   data_ld, reg_wrt_ld            load result from the LSU
//   alu_wb_vld                     ALU owns the RF write port this cycle
//   rf_we, rf_waddr, rf_wdata      register file write
//   rob_cmpl_vld, rob_cmpl_indx    ROB completion
//   wb_full                        back-pressure to the LSU (one-slot skid)
//   ovf_err                        sticky overflow error
module ld_wb_sink
    import ld_wb_sink_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int IDX_W  = IDX_W_DEF,
    parameter int PREG_W = PREG_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flsh,
    input  logic              vld_ld,
    input  logic [IDX_W-1:0]  indx_ld,
    input  logic [PREG_W-1:0] phy_addr_ld,
    input  logic [DATA_W-1:0] data_ld,
    input  logic              reg_wrt_ld,
    input  logic              alu_wb_vld,
    output logic              rf_we,
    output logic [PREG_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rob_cmpl_vld,
    output logic [IDX_W-1:0]  rob_cmpl_indx,
    output logic              wb_full,
    output logic              ovf_err
);

    localparam int CNT_W = clog2(DEPTH) + 1;

    // Same layout as wb_entry_t, sized by this instance's parameters.
    typedef struct packed {
        logic [IDX_W-1:0]  indx;
        logic [PREG_W-1:0] preg;
        logic [DATA_W-1:0] data;
        logic              reg_wrt;
    } entry_t;

    entry_t           w_push_entry;
    entry_t           w_head;
    logic [CNT_W-1:0] w_count;
    logic             w_empty;
    logic             w_pop;

    logic              r_rf_we;
    logic [PREG_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0] r_rf_wdata;
    logic              r_rob_cmpl_vld;
    logic [IDX_W-1:0]  r_rob_cmpl_indx;

    assign w_push_entry = '{indx: indx_ld, preg: phy_addr_ld,
                            data: data_ld, reg_wrt: reg_wrt_ld};

    ld_wb_sink_wb_fifo #(
        .DEPTH (DEPTH),
        .W     ($bits(entry_t))
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .i_flsh     (flsh),
        .i_push_req (vld_ld),
        .i_wdata    (w_push_entry),
        .i_pop      (w_pop),
        .o_head     (w_head),
        .o_count    (w_count),
        .o_empty    (w_empty),
        .o_ovf_err  (ovf_err)
    );

    // Completion-only heads never need the RF port, so the ALU cannot block
    // them; strict FIFO order still holds because only the head is examined.
    assign w_pop = !w_empty && !flsh && (!w_head.reg_wrt || !alu_wb_vld);

    assign wb_full = (w_count >= CNT_W'(DEPTH - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rf_we         <= 1'b0;
            r_rf_waddr      <= '0;
            r_rf_wdata      <= '0;
            r_rob_cmpl_vld  <= 1'b0;
            r_rob_cmpl_indx <= '0;
        end else begin
            r_rf_we        <= w_pop && w_head.reg_wrt;
            r_rob_cmpl_vld <= w_pop;
            if (w_pop) begin
                r_rf_waddr      <= w_head.preg;
                r_rf_wdata      <= w_head.data;
                r_rob_cmpl_indx <= w_head.indx;
            end
        end
    end

    assign rf_we         = r_rf_we;
    assign rf_waddr      = r_rf_waddr;
    assign rf_wdata      = r_rf_wdata;
    assign rob_cmpl_vld  = r_rob_cmpl_vld;
    assign rob_cmpl_indx = r_rob_cmpl_indx;

endmodule

// File: tb/tb_ld_wb_sink.sv
// Directed testbench for ld_wb_sink: single load, port conflict,
// completion-only under conflict, fill/overflow/drain, flush, pointer wrap
// and asynchronous reset mid-stream.
module tb_ld_wb_sink;
    import ld_wb_sink_pkg::*;

    logic        clk;
    logic        rst;
    logic        flsh;
    logic        vld_ld;
    logic [5:0]  indx_ld;
    logic [5:0]  phy_addr_ld;
    logic [15:0] data_ld;
    logic        reg_wrt_ld;
    logic        alu_wb_vld;
    logic        rf_we;
    logic [5:0]  rf_waddr;
    logic [15:0] rf_wdata;
    logic        rob_cmpl_vld;
    logic [5:0]  rob_cmpl_indx;
    logic        wb_full;
    logic        ovf_err;

    int n_checks;
    int n_errors;

    ld_wb_sink #(.DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .flsh          (flsh),
        .vld_ld        (vld_ld),
        .indx_ld       (indx_ld),
        .phy_addr_ld   (phy_addr_ld),
        .data_ld       (data_ld),
        .reg_wrt_ld    (reg_wrt_ld),
        .alu_wb_vld    (alu_wb_vld),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .rob_cmpl_vld  (rob_cmpl_vld),
        .rob_cmpl_indx (rob_cmpl_indx),
        .wb_full       (wb_full),
        .ovf_err       (ovf_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge, then settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input wb_entry_t e);
        vld_ld      = v;
        indx_ld     = e.indx;
        phy_addr_ld = e.preg;
        data_ld     = e.data;
        reg_wrt_ld  = e.reg_wrt;
    endtask

    task automatic idle_out(input string tag);
        check({tag, "_we"},   32'(rf_we),        32'd0);
        check({tag, "_cmpl"}, 32'(rob_cmpl_vld), 32'd0);
    endtask

    task automatic expect_out(input string tag, input logic we, input logic [5:0] preg,
                              input logic [15:0] data, input logic [5:0] indx);
        check({tag, "_we"},    32'(rf_we),         32'(we));
        check({tag, "_waddr"}, 32'(rf_waddr),      32'(preg));
        check({tag, "_wdata"}, 32'(rf_wdata),      32'(data));
        check({tag, "_cmpl"},  32'(rob_cmpl_vld),  32'd1);
        check({tag, "_indx"},  32'(rob_cmpl_indx), 32'(indx));
    endtask

    wb_entry_t e;

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        rst        = 1'b1;
        flsh       = 1'b0;
        alu_wb_vld = 1'b0;
        e          = '0;
        drive(1'b0, e);

        // Reset state
        #12;
        check("rst_we",    32'(rf_we),         32'd0);
        check("rst_waddr", 32'(rf_waddr),      32'd0);
        check("rst_wdata", 32'(rf_wdata),      32'd0);
        check("rst_cmpl",  32'(rob_cmpl_vld),  32'd0);
        check("rst_indx",  32'(rob_cmpl_indx), 32'd0);
        check("rst_full",  32'(wb_full),       32'd0);
        check("rst_ovf",   32'(ovf_err),       32'd0);
        rst = 1'b0;
        step();

        // Single load: two-edge latency, one-cycle pulse
        e = '{indx: 6'd1, preg: 6'd37, data: 16'hFFFF, reg_wrt: 1'b1};
        drive(1'b1, e);
        step();
        drive(1'b0, e);
        idle_out("single_lat");
        step();
        expect_out("single", 1'b1, 6'd37, 16'hFFFF, 6'd1);
        step();
        idle_out("single_end");
        check("single_hold_waddr", 32'(rf_waddr), 32'd37);

        // Port conflict: ALU holds the port for 3 cycles
        alu_wb_vld = 1'b1;
        e = '{indx: 6'd2, preg: 6'd28, data: 16'h0101, reg_wrt: 1'b1};
        drive(1'b1, e);
        step();
        drive(1'b0, e);
        idle_out("conf_c1");
        step();
        idle_out("conf_c2");
        step();
        idle_out("conf_c3");
        alu_wb_vld = 1'b0;
        step();
        expect_out("conf_rel", 1'b1, 6'd28, 16'h0101, 6'd2);
        step();
        idle_out("conf_end");

        // Completion-only entry is not blocked by the ALU
        alu_wb_vld = 1'b1;
        e = '{indx: 6'd5, preg: 6'd9, data: 16'h1234, reg_wrt: 1'b0};
        drive(1'b1, e);
        step();
        drive(1'b0, e);
        step();
        expect_out("cmplonly", 1'b0, 6'd9, 16'h1234, 6'd5);
        step();
        idle_out("cmplonly_end");

        // Fill, back-pressure and overflow (ALU still holds the port)
        for (int i = 1; i <= 5; i++) begin
            e = '{indx: 6'(i), preg: 6'(10 + i), data: 16'(16'hA000 + i), reg_wrt: 1'b1};
            drive(1'b1, e);
            step();
            idle_out($sformatf("fill%0d", i));
            check($sformatf("fill%0d_full", i), 32'(wb_full), (i >= 3) ? 32'd1 : 32'd0);
            check($sformatf("fill%0d_ovf", i),  32'(ovf_err), (i >= 5) ? 32'd1 : 32'd0);
        end
        drive(1'b0, e);
        alu_wb_vld = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            expect_out($sformatf("drain%0d", i), 1'b1, 6'(10 + i), 16'(16'hA000 + i), 6'(i));
        end
        step();
        idle_out("drain_dropped");
        check("drain_full", 32'(wb_full), 32'd0);
        check("drain_ovf_sticky", 32'(ovf_err), 32'd1);

        // Flush: two buffered entries plus a same-cycle push all vanish
        alu_wb_vld = 1'b1;
        for (int i = 10; i <= 11; i++) begin
            e = '{indx: 6'(i), preg: 6'(i), data: 16'(i), reg_wrt: 1'b1};
            drive(1'b1, e);
            step();
        end
        e = '{indx: 6'd12, preg: 6'd12, data: 16'd12, reg_wrt: 1'b1};
        drive(1'b1, e);
        flsh = 1'b1;
        step();
        flsh = 1'b0;
        drive(1'b0, e);
        alu_wb_vld = 1'b0;
        check("flush_full", 32'(wb_full), 32'd0);
        check("flush_ovf", 32'(ovf_err), 32'd1);
        idle_out("flush_c0");
        for (int i = 1; i <= 3; i++) begin
            step();
            idle_out($sformatf("flush_c%0d", i));
        end
        // Empty after flush: a fresh push is the very next result out
        e = '{indx: 6'd13, preg: 6'd3, data: 16'h0013, reg_wrt: 1'b0};
        drive(1'b1, e);
        step();
        drive(1'b0, e);
        idle_out("postflush_lat");
        step();
        expect_out("postflush", 1'b0, 6'd3, 16'h0013, 6'd13);
        step();

        // Wrap: 10 back-to-back loads, one completion per cycle in order
        for (int i = 0; i < 10; i++) begin
            e = '{indx: 6'(20 + i), preg: 6'(i), data: 16'(16'h0111 * i), reg_wrt: 1'b1};
            drive(1'b1, e);
            step();
            if (i > 0)
                expect_out($sformatf("wrap%0d", i - 1), 1'b1, 6'(i - 1),
                           16'(16'h0111 * (i - 1)), 6'(19 + i));
        end
        drive(1'b0, e);
        step();
        expect_out("wrap9", 1'b1, 6'd9, 16'h0999, 6'd29);
        step();
        idle_out("wrap_end");

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            e = '{indx: 6'(40 + i), preg: 6'(30 + i), data: 16'(16'hBEE0 + i), reg_wrt: 1'b1};
            drive(1'b1, e);
            step();
        end
        drive(1'b0, e);
        check("arst_pre_cmpl", 32'(rob_cmpl_vld), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_we",    32'(rf_we),         32'd0);
        check("arst_waddr", 32'(rf_waddr),      32'd0);
        check("arst_wdata", 32'(rf_wdata),      32'd0);
        check("arst_cmpl",  32'(rob_cmpl_vld),  32'd0);
        check("arst_indx",  32'(rob_cmpl_indx), 32'd0);
        check("arst_ovf",   32'(ovf_err),       32'd0);
        #1 rst = 1'b0;
        // Buffered entries are gone; a fresh push is the first result
        e = '{indx: 6'd50, preg: 6'd50, data: 16'h5050, reg_wrt: 1'b1};
        drive(1'b1, e);
        step();
        drive(1'b0, e);
        idle_out("arst_lat");
        step();
        expect_out("arst_first", 1'b1, 6'd50, 16'h5050, 6'd50);
        step();
        idle_out("arst_end");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
